ccff_loader: RTL and testbench

Configuration sequencer for the FPGA fabric's parallel configuration-chain interface. It accepts a bitstream as a stream of NUM_CHAINS-bit words, one bit per chain, and performs these steps in order: pulse the fabric reset, shift exactly CHAIN_LEN words into the chains, then verify loopback on the chain tails. It sits between the SoC-side bitstream source (DMA or host bridge) and the fabric's config_enable, pReset, prog_clk clock-enable and ccff_head inputs; it also observes ccff_tail.

---
 rtl/ccff_loader.sv | 161 ++++++++++++++++
 tb/tb_ccff_loader.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ccff_loader.sv
`default_nettype none
// ============================================================================
// Module   : ccff_loader
// Purpose  : Configuration sequencer for the fabric's parallel configuration
//            chains. On start it pulses the fabric reset, streams exactly
//            CHAIN_LEN words (one bit per chain) into the chains, then checks
//            that the first word has reached the chain tails.
// Ports    : prog_clk, pReset (async, active high)
//            start                       - begin a configuration (IDLE/DONE/ERROR)
//            s_valid/s_ready/s_data      - bitstream word stream
//            ccff_tail                   - chain outputs from the fabric
//            ccff_head, shift_en         - registered chain data + shift enable
//            config_enable, fab_reset    - fabric mode / reset controls
//            busy, done, error           - status
// Revision : 1.0 - initial release
// ============================================================================
module ccff_loader #(
  parameter int NUM_CHAINS = 12,
  parameter int CHAIN_LEN  = 4096,
  parameter int RST_CYCLES = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                  prog_clk,
  input  logic                  pReset,
  input  logic                  start,
  input  logic                  s_valid,
  input  logic [NUM_CHAINS-1:0] s_data,
  output logic                  s_ready,
  input  logic [NUM_CHAINS-1:0] ccff_tail,
  output logic [NUM_CHAINS-1:0] ccff_head,
  output logic                  shift_en,
  output logic                  config_enable,
  output logic                  fab_reset,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int WCW       = $clog2(CHAIN_LEN + 1);
  localparam int PHASE_MAX = (RST_CYCLES > 2) ? RST_CYCLES : 2;
  localparam int PW        = $clog2(PHASE_MAX);
  localparam int TW        = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RST   = 3'd1,
    S_SHIFT = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4,
    S_ERROR = 3'd5
  } state_t;

  state_t                  state_q, state_d;
  logic [WCW-1:0]          wcnt_q, wcnt_d;     // accepted words
  logic [PW-1:0]           phase_q, phase_d;   // cycle counter for RST and CHECK
  logic [TW-1:0]           idle_q, idle_d;     // consecutive idle SHIFT cycles
  logic [NUM_CHAINS-1:0]   word1_q, word1_d;   // first word, expected at the tails
  logic [NUM_CHAINS-1:0]   head_q, head_d;
  logic                    shift_en_q, shift_en_d;
  logic                    accept;

  // Status and control outputs are pure decodes of the state register.
  assign s_ready       = (state_q == S_SHIFT) && (wcnt_q < WCW'(CHAIN_LEN));
  assign fab_reset     = (state_q == S_RST);
  assign config_enable = (state_q == S_RST) || (state_q == S_SHIFT) || (state_q == S_CHECK);
  assign busy          = config_enable;
  assign done          = (state_q == S_DONE);
  assign error         = (state_q == S_ERROR);
  assign ccff_head     = head_q;
  assign shift_en      = shift_en_q;
  assign accept        = s_valid && s_ready;

  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    phase_d    = phase_q;
    idle_d     = idle_q;
    word1_d    = word1_q;
    head_d     = head_q;
    shift_en_d = 1'b0;

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d = S_RST;
          wcnt_d  = '0;
          phase_d = '0;
          idle_d  = '0;
        end
      end

      S_RST: begin
        if (phase_q == PW'(RST_CYCLES - 1)) begin
          state_d = S_SHIFT;
          phase_d = '0;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end

      S_SHIFT: begin
        if (accept) begin
          head_d     = s_data;
          shift_en_d = 1'b1;
          wcnt_d     = wcnt_q + 1'b1;
          idle_d     = '0;
          if (wcnt_q == '0) begin
            word1_d = s_data;
          end
          // Last word: the fabric still shifts it on the next edge, so
          // CHECK spends one cycle waiting before it samples the tails.
          if (wcnt_q == WCW'(CHAIN_LEN - 1)) begin
            state_d = S_CHECK;
            phase_d = '0;
          end
        end else if (TIMEOUT != 0) begin
          if (idle_q == TW'(TIMEOUT - 1)) begin
            state_d = S_ERROR;
          end else begin
            idle_d = idle_q + 1'b1;
          end
        end
      end

      S_CHECK: begin
        if (phase_q == '0) begin
          phase_d = PW'(1);
        end else begin
          state_d = (ccff_tail == word1_q) ? S_DONE : S_ERROR;
          phase_d = '0;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      state_q    <= S_IDLE;
      wcnt_q     <= '0;
      phase_q    <= '0;
      idle_q     <= '0;
      word1_q    <= '0;
      head_q     <= '0;
      shift_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      phase_q    <= phase_d;
      idle_q     <= idle_d;
      word1_q    <= word1_d;
      head_q     <= head_d;
      shift_en_q <= shift_en_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ccff_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_ccff_loader
// Purpose  : Directed self-checking bench for ccff_loader with a behavioural
//            model of the configuration chains (CHAIN_LEN deep per chain).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ccff_loader;

  localparam int NC  = 12;
  localparam int CL  = 8;
  localparam int RC  = 4;
  localparam int TMO = 3;

  logic          prog_clk = 1'b0;
  logic          pReset;
  logic          start;
  logic          s_valid;
  logic [NC-1:0] s_data;
  logic          s_ready;
  logic [NC-1:0] ccff_tail;
  logic [NC-1:0] ccff_head;
  logic          shift_en;
  logic          config_enable;
  logic          fab_reset;
  logic          busy;
  logic          done;
  logic          error;

  int checks = 0;
  int errors = 0;
  int shift_cnt = 0;

  logic [NC-1:0] chain_mem [CL];
  logic [NC-1:0] corrupt = '0;

  ccff_loader #(
    .NUM_CHAINS (NC),
    .CHAIN_LEN  (CL),
    .RST_CYCLES (RC),
    .TIMEOUT    (TMO)
  ) dut (
    .prog_clk      (prog_clk),
    .pReset        (pReset),
    .start         (start),
    .s_valid       (s_valid),
    .s_data        (s_data),
    .s_ready       (s_ready),
    .ccff_tail     (ccff_tail),
    .ccff_head     (ccff_head),
    .shift_en      (shift_en),
    .config_enable (config_enable),
    .fab_reset     (fab_reset),
    .busy          (busy),
    .done          (done),
    .error         (error)
  );

  always #5 prog_clk = ~prog_clk;

  // Fabric chain model: one shift per prog_clk edge while shift_en is high.
  always @(posedge prog_clk) begin
    if (shift_en === 1'b1) begin
      for (int k = CL - 1; k > 0; k--) chain_mem[k] <= chain_mem[k-1];
      chain_mem[0] <= ccff_head;
      shift_cnt = shift_cnt + 1;
    end
  end
  assign ccff_tail = chain_mem[CL-1] ^ corrupt;

  initial begin
    for (int k = 0; k < CL; k++) chain_mem[k] = '0;
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge prog_clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Called in the first RST cycle; returns in the first SHIFT cycle.
  task automatic rst_phase();
    for (int i = 0; i < RC; i++) begin
      check_eq("fab_reset_hi", {31'd0, fab_reset}, 32'd1);
      check_eq("rst_ready", {31'd0, s_ready}, 32'd0);
      check_eq("rst_cfg", {31'd0, config_enable}, 32'd1);
      tick();
    end
    check_eq("fab_reset_lo", {31'd0, fab_reset}, 32'd0);
    check_eq("ready_up", {31'd0, s_ready}, 32'd1);
    check_eq("shift_pre", {31'd0, shift_en}, 32'd0);
  endtask

  // Sends n words first_val.. ; gappy inserts random idles (never 3 in a row).
  task automatic feed(input int n, input bit gappy, input int first_val);
    int  sent;
    int  idle;
    bit  v;
    sent = 0;
    idle = 0;
    while (sent < n) begin
      v = gappy ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (idle >= 2) v = 1'b1;
      s_valid = v;
      s_data  = NC'(first_val + sent);
      tick();
      check_eq("shift_en", {31'd0, shift_en}, {31'd0, v});
      if (v) begin
        check_eq("head", {20'd0, ccff_head}, 32'(first_val + sent));
        sent++;
        idle = 0;
      end else begin
        idle++;
      end
    end
    s_valid = 1'b0;
  endtask

  // Called in cycle L->L+1 after the last accept.
  task automatic finish_check(input bit exp_done);
    check_eq("last_ready", {31'd0, s_ready}, 32'd0);
    tick();
    check_eq("chk_busy", {31'd0, busy}, 32'd1);
    check_eq("chk_done_early", {31'd0, done}, 32'd0);
    check_eq("chk_shift", {31'd0, shift_en}, 32'd0);
    tick();
    check_eq("done", {31'd0, done}, {31'd0, exp_done});
    check_eq("error", {31'd0, error}, {31'd0, !exp_done});
    check_eq("cfg_off", {31'd0, config_enable}, 32'd0);
    check_eq("busy_off", {31'd0, busy}, 32'd0);
  endtask

  int base;

  initial begin
    pReset  = 1'b1;
    start   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    tick();
    tick();
    check_eq("reset_outs", {19'd0, ccff_head, shift_en, config_enable, fab_reset,
                            s_ready, busy, done, error}, 32'd0);
    pReset = 1'b0;
    tick();

    // Valid outside SHIFT is ignored.
    s_valid = 1'b1;
    s_data  = 12'hFFF;
    tick();
    check_eq("idle_valid", {19'd0, ccff_head, shift_en}, 32'd0);
    s_valid = 1'b0;

    // Nominal load
    base = shift_cnt;
    do_start();
    check_eq("busy_rst", {31'd0, busy}, 32'd1);
    rst_phase();
    feed(CL, 1'b0, 1);
    finish_check(1'b1);
    check_eq("nom_shifts", 32'(shift_cnt - base), 32'd8);

    // Restart from DONE, then gappy stream
    do_start();
    check_eq("restart_done_clr", {30'd0, done, error}, 32'd0);
    base = shift_cnt;
    rst_phase();
    feed(CL, 1'b1, 12'h100);
    finish_check(1'b1);
    check_eq("gap_shifts", 32'(shift_cnt - base), 32'd8);

    // Loopback failure on bit 5
    corrupt = 12'h020;
    do_start();
    rst_phase();
    feed(CL, 1'b0, 12'h0A5);
    finish_check(1'b0);
    corrupt = '0;

    // Restart from ERROR, then timeout after 3 words
    do_start();
    check_eq("restart_err_clr", {30'd0, done, error}, 32'd0);
    rst_phase();
    feed(3, 1'b0, 12'h300);
    tick();
    check_eq("tmo_idle1", {31'd0, error}, 32'd0);
    tick();
    check_eq("tmo_idle2", {31'd0, error}, 32'd0);
    tick();
    check_eq("tmo_err", {31'd0, error}, 32'd1);
    check_eq("tmo_ready", {31'd0, s_ready}, 32'd0);
    check_eq("tmo_shift", {31'd0, shift_en}, 32'd0);
    check_eq("tmo_cfg", {31'd0, config_enable}, 32'd0);
    tick();
    check_eq("tmo_shift_after", {31'd0, shift_en}, 32'd0);

    // Reset mid-load, asynchronous
    do_start();
    rst_phase();
    feed(4, 1'b0, 12'h400);
    #2;
    pReset = 1'b1;
    #1;
    check_eq("async_rst_outs", {19'd0, ccff_head, shift_en, config_enable, fab_reset,
                                s_ready, busy, done, error}, 32'd0);
    tick();
    pReset = 1'b0;
    tick();
    check_eq("post_rst_idle", {30'd0, busy, done}, 32'd0);
    do_start();
    rst_phase();
    feed(CL, 1'b0, 12'h501);
    finish_check(1'b1);

    // Start while in SHIFT is ignored; count continues from 4
    do_start();
    rst_phase();
    feed(4, 1'b0, 12'h601);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("shift_start_rst", {31'd0, fab_reset}, 32'd0);
    check_eq("shift_start_ready", {31'd0, s_ready}, 32'd1);
    feed(4, 1'b0, 12'h605);
    finish_check(1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
